// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode and branch-select encodings, plus the arbiter FSM states.
package alu_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t ALU_NOP   = 5'd0,  ALU_ADD   = 5'd1,  ALU_SUB   = 5'd2,  ALU_XOR  = 5'd3;
  localparam alu_op_t ALU_OR    = 5'd4,  ALU_AND   = 5'd5,  ALU_SLL   = 5'd6,  ALU_SRL  = 5'd7;
  localparam alu_op_t ALU_SRA   = 5'd8,  ALU_SLT   = 5'd9,  ALU_SLTU  = 5'd10, ALU_LUI  = 5'd11;
  localparam alu_op_t ALU_MUL   = 5'd12, ALU_MULH  = 5'd13, ALU_DIV   = 5'd14, ALU_DIVU = 5'd15;
  localparam alu_op_t ALU_REM   = 5'd16, ALU_LB    = 5'd17, ALU_LH    = 5'd18, ALU_LBU  = 5'd19;
  localparam alu_op_t ALU_LHU   = 5'd20, ALU_LW    = 5'd21, ALU_SW    = 5'd22, ALU_BEQ  = 5'd23;
  localparam alu_op_t ALU_BNE   = 5'd24, ALU_BLT   = 5'd25, ALU_BGE   = 5'd26, ALU_BLTU = 5'd27;
  localparam alu_op_t ALU_BGEU  = 5'd28, ALU_AUIPC = 5'd29, ALU_JAL   = 5'd30, ALU_JALR = 5'd31;

  typedef logic [1:0] br_sel_t;

  localparam br_sel_t BR_NONE      = 2'b00;
  localparam br_sel_t BR_NOT_TAKEN = 2'b01;
  localparam br_sel_t BR_TAKEN     = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational grant, last_grant advanced on upd_i.
// On a tie the port that did not win last time gets the grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_id_o = req_i[1] & (~req_i[0] | ~last_q);
    gnt_o    = {req_i[1] & gnt_id_o, req_i[0] & ~gnt_id_o};
    last_d   = upd_i ? gnt_id_o : last_q;
  end

  // Reset to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; one transaction in flight,
// accept -> one EXEC cycle -> response held until the owner takes it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_br,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic              alu_en_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic [1:0]        alu_br_i
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  br_sel_t           br_q, br_d;

  logic [1:0] gnt;
  logic       gnt_id;
  logic       accept;
  logic       idle;

  assign idle = (state_q == ST_IDLE);

  // Requests are only visible to the picker in IDLE, so a non-owner is ignored elsewhere.
  rr_arb2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({req1_valid & idle, req0_valid & idle}),
    .upd_i    (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign accept = |gnt;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    data_d     = data_q;
    br_d       = br_q;
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    alu_en_o   = 1'b0;
    alu_op_o   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = gnt_id;
          op_d    = gnt_id ? req1_op : req0_op;
          a_d     = gnt_id ? req1_a  : req0_a;
          b_d     = gnt_id ? req1_b  : req0_b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_en_o = 1'b1;
        alu_op_o = op_q;
        data_d   = alu_out_i;
        br_d     = alu_br_i;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      br_q    <= BR_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      br_q    <= br_d;
    end
  end

  // Operands stay at their last values outside EXEC to limit toggling into the ALU.
  assign alu_a_o  = a_q;
  assign alu_b_o  = b_q;
  assign rsp_data = data_q;
  assign rsp_br   = br_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the ALU-side ports.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_br;
  logic [4:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic        alu_en_o;
  logic [31:0] alu_out_i;
  logic [1:0]  alu_br_i;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_br(rsp_br),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_en_o(alu_en_o),
    .alu_out_i(alu_out_i), .alu_br_i(alu_br_i)
  );

  // Stand-in ALU: only the opcodes the bench uses; anything else gives 0/00.
  always_comb begin
    alu_out_i = '0;
    alu_br_i  = 2'b00;
    case (alu_op_o)
      5'd1:  alu_out_i = alu_a_o + alu_b_o;
      5'd2:  alu_out_i = alu_a_o - alu_b_o;
      5'd3:  alu_out_i = alu_a_o ^ alu_b_o;
      5'd21: alu_out_i = (alu_a_o + alu_b_o) & ~32'd3;
      5'd23: alu_br_i  = (alu_a_o == alu_b_o) ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;
    req0_op = 5'd1; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1; #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL rst_accept got=%b exp=1", req0_ready); end
    tick; req0_valid = 1'b0;
    total++; if (alu_en_o !== 1'b1) begin bad++; $display("FAIL rst_exec_en got=%b exp=1", alu_en_o); end
    #2; rst_n = 1'b0; #1;
    total++; if (alu_en_o !== 1'b0) begin bad++; $display("FAIL rst_async_en got=%b exp=0", alu_en_o); end
    total++; if (alu_op_o !== 5'd0) begin bad++; $display("FAIL rst_async_op got=%0d exp=0", alu_op_o); end
    total++; if (alu_a_o !== 32'd0 || alu_b_o !== 32'd0) begin bad++; $display("FAIL rst_async_ab got=%h/%h exp=0/0", alu_a_o, alu_b_o); end
    total++; if (rsp_data !== 32'd0 || rsp_br !== 2'b00) begin bad++; $display("FAIL rst_async_rsp got=%h/%b exp=0/00", rsp_data, rsp_br); end
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL rst_async_hs got=%b%b%b%b exp=0000", rsp0_valid, rsp1_valid, req0_ready, req1_ready); end
    tick; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++; if (rsp0_valid !== 1'b0 || alu_en_o !== 1'b0) begin bad++; $display("FAIL rst_no_rsp cyc=%0d got=%b/%b exp=0/0", i, rsp0_valid, alu_en_o); end
    end
  endtask

  task automatic test_single_add;
    req0_op = 5'd1; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1; #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL add_ready got=%b%b exp=10", req0_ready, req1_ready); end
    total++; if (alu_en_o !== 1'b0) begin bad++; $display("FAIL add_en_n got=%b exp=0", alu_en_o); end
    tick; req0_valid = 1'b0;
    total++; if (alu_en_o !== 1'b1 || alu_op_o !== 5'd1) begin bad++; $display("FAIL add_exec got=%b/%0d exp=1/1", alu_en_o, alu_op_o); end
    total++; if (alu_a_o !== 32'd5 || alu_b_o !== 32'd7) begin bad++; $display("FAIL add_operands got=%0d/%0d exp=5/7", alu_a_o, alu_b_o); end
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL add_early_rsp got=%b exp=0", rsp0_valid); end
    tick;
    total++; if (rsp0_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_br !== 2'b00) begin bad++; $display("FAIL add_rsp got=%b/%0d/%b exp=1/12/00", rsp0_valid, rsp_data, rsp_br); end
    total++; if (alu_en_o !== 1'b0 || alu_op_o !== 5'd0 || alu_a_o !== 32'd5) begin bad++; $display("FAIL add_post_exec got=%b/%0d/%0d exp=0/0/5", alu_en_o, alu_op_o, alu_a_o); end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (rsp0_valid !== 1'b1 || rsp_data !== 32'd12) begin bad++; $display("FAIL add_hold cyc=%0d got=%b/%0d exp=1/12", i, rsp0_valid, rsp_data); end
    end
    rsp0_ready = 1'b1; tick; rsp0_ready = 1'b0;
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL add_release got=%b exp=0", rsp0_valid); end
  endtask

  task automatic test_contention;
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;
    req0_op = 5'd2; req0_a = 32'd10;  req0_b = 32'd3;  req0_valid = 1'b1;
    req1_op = 5'd3; req1_a = 32'hF0;  req1_b = 32'h0F; req1_valid = 1'b1; #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL cont_first got=%b%b exp=10", req0_ready, req1_ready); end
    tick;
    total++; if (alu_op_o !== 5'd2 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL cont_exec0 got=%0d/%b%b exp=2/00", alu_op_o, req0_ready, req1_ready); end
    tick;
    total++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_data !== 32'd7) begin bad++; $display("FAIL cont_rsp0 got=%b%b/%0d exp=10/7", rsp0_valid, rsp1_valid, rsp_data); end
    rsp0_ready = 1'b1; tick; rsp0_ready = 1'b0; #1;
    total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++; $display("FAIL cont_second got=%b%b exp=01", req0_ready, req1_ready); end
    tick;
    total++; if (alu_op_o !== 5'd3 || alu_a_o !== 32'hF0) begin bad++; $display("FAIL cont_exec1 got=%0d/%h exp=3/f0", alu_op_o, alu_a_o); end
    tick;
    total++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_data !== 32'hFF) begin bad++; $display("FAIL cont_rsp1 got=%b%b/%h exp=01/ff", rsp0_valid, rsp1_valid, rsp_data); end
    rsp1_ready = 1'b1; tick; rsp1_ready = 1'b0; #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL cont_third got=%b%b exp=10", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0; #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL cont_drop_ready got=%b exp=0", req0_ready); end
    tick;
    total++; if (alu_en_o !== 1'b0 || rsp0_valid !== 1'b0) begin bad++; $display("FAIL cont_drop_idle got=%b/%b exp=0/0", alu_en_o, rsp0_valid); end
  endtask

  task automatic test_branch;
    req1_op = 5'd23; req1_a = 32'h20; req1_b = 32'h20; req1_valid = 1'b1; #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL br_accept got=%b exp=1", req1_ready); end
    tick; req1_valid = 1'b0; tick;
    total++; if (rsp1_valid !== 1'b1 || rsp_br !== 2'b10 || rsp0_valid !== 1'b0) begin bad++; $display("FAIL br_taken got=%b/%b/%b exp=1/10/0", rsp1_valid, rsp_br, rsp0_valid); end
    rsp1_ready = 1'b1; tick; rsp1_ready = 1'b0;
    req1_b = 32'h21; req1_valid = 1'b1; #1; tick; req1_valid = 1'b0;
    total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL br_no_rsp0 got=%b exp=0", rsp0_valid); end
    tick;
    total++; if (rsp1_valid !== 1'b1 || rsp_br !== 2'b01 || rsp0_valid !== 1'b0) begin bad++; $display("FAIL br_not_taken got=%b/%b/%b exp=1/01/0", rsp1_valid, rsp_br, rsp0_valid); end
    rsp1_ready = 1'b1; tick; rsp1_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    req0_op = 5'd1; req0_a = 32'd1; req0_b = 32'd2; req0_valid = 1'b1; #1;
    tick; req0_valid = 1'b0; tick;
    req1_op = 5'd3; req1_a = 32'hAA; req1_b = 32'h55; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (req1_ready !== 1'b0 || rsp0_valid !== 1'b1 || rsp_data !== 32'd3) begin bad++; $display("FAIL bp_stall cyc=%0d got=%b/%b/%0d exp=0/1/3", i, req1_ready, rsp0_valid, rsp_data); end
      tick;
    end
    rsp0_ready = 1'b1; #1;
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL bp_same_cycle got=%b exp=0", req1_ready); end
    tick; rsp0_ready = 1'b0; #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL bp_accept got=%b exp=1", req1_ready); end
    tick; req1_valid = 1'b0;
    total++; if (alu_op_o !== 5'd3 || alu_en_o !== 1'b1) begin bad++; $display("FAIL bp_exec got=%0d/%b exp=3/1", alu_op_o, alu_en_o); end
    tick;
    total++; if (rsp1_valid !== 1'b1 || rsp_data !== 32'hFF) begin bad++; $display("FAIL bp_rsp1 got=%b/%h exp=1/ff", rsp1_valid, rsp_data); end
    rsp1_ready = 1'b1; tick; rsp1_ready = 1'b0;
  endtask

  task automatic test_lw;
    req0_op = 5'd21; req0_a = 32'h1003; req0_b = 32'h2; req0_valid = 1'b1; #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL lw_accept got=%b exp=1", req0_ready); end
    tick; req0_valid = 1'b0;
    total++; if (alu_op_o !== 5'd21) begin bad++; $display("FAIL lw_exec_op got=%0d exp=21", alu_op_o); end
    tick;
    total++; if (rsp0_valid !== 1'b1 || rsp_data !== 32'h1004) begin bad++; $display("FAIL lw_rsp got=%b/%h exp=1/1004", rsp0_valid, rsp_data); end
    total++; if (alu_op_o !== 5'd0 || alu_en_o !== 1'b0) begin bad++; $display("FAIL lw_op_clear got=%0d/%b exp=0/0", alu_op_o, alu_en_o); end
    rsp0_ready = 1'b1; tick; rsp0_ready = 1'b0;
  endtask

  task automatic test_nop;
    req1_op = 5'd0; req1_a = 32'd9; req1_b = 32'd9; req1_valid = 1'b1; #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL nop_accept got=%b exp=1", req1_ready); end
    tick; req1_valid = 1'b0; tick;
    total++; if (rsp1_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_br !== 2'b00) begin bad++; $display("FAIL nop_rsp got=%b/%h/%b exp=1/0/00", rsp1_valid, rsp_data, rsp_br); end
    rsp1_ready = 1'b1; tick; rsp1_ready = 1'b0;
    total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL nop_release got=%b exp=0", rsp1_valid); end
  endtask

  initial begin
    test_reset;
    test_single_add;
    test_contention;
    test_branch;
    test_back_to_back;
    test_lw;
    test_nop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
